// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter
//   Round-robin arbiter that merges NUM_INPUTS valid/ready streams into one
//   registered output stream. The search for the next grant starts at the
//   stream after the last one granted, so continuously valid streams are
//   served in strict rotation. The output register drains and reloads in
//   the same cycle, giving one beat per cycle under full load.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   data_in        : per-stream payload, unpacked [NUM_INPUTS-1:0]
//   data_in_valid  : per-stream valid
//   data_in_ready  : per-stream ready, at most one bit set
//   data_out       : registered payload of the accepted beat
//   data_out_valid : output register holds a beat
//   data_out_ready : downstream accepts the output beat
//   select         : registered index of the stream that produced data_out
module rr_stream_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32,
    localparam int SELECT_WIDTH = $clog2(NUM_INPUTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   data_in [NUM_INPUTS-1:0],
    input  logic [NUM_INPUTS-1:0]   data_in_valid,
    output logic [NUM_INPUTS-1:0]   data_in_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_out_valid,
    input  logic                    data_out_ready,
    output logic [SELECT_WIDTH-1:0] select
);

    logic [SELECT_WIDTH-1:0] r_ptr;
    logic [SELECT_WIDTH-1:0] r_select;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;

    logic [SELECT_WIDTH-1:0] w_grant;
    logic [SELECT_WIDTH-1:0] w_ptr_next;
    logic [SELECT_WIDTH:0]   w_idx;
    logic                    w_any;
    logic                    w_load;
    logic                    w_xfer;

    // Search from r_ptr upwards with wrap. w_idx carries one spare bit so
    // r_ptr + k never overflows before the wrap subtraction.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            w_idx = {1'b0, r_ptr} + (SELECT_WIDTH+1)'(k);
            if (w_idx >= (SELECT_WIDTH+1)'(NUM_INPUTS)) begin
                w_idx = w_idx - (SELECT_WIDTH+1)'(NUM_INPUTS);
            end
            if (!w_any && data_in_valid[w_idx[SELECT_WIDTH-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_idx[SELECT_WIDTH-1:0];
            end
        end
    end

    assign w_load = !r_valid || data_out_ready;
    // rst_n gates the transfer so no ready is offered while held in reset.
    assign w_xfer = rst_n && w_load && w_any;

    assign w_ptr_next = (w_grant == SELECT_WIDTH'(NUM_INPUTS - 1))
                        ? '0 : w_grant + SELECT_WIDTH'(1);

    always_comb begin
        data_in_ready = '0;
        if (w_xfer) begin
            data_in_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_select <= '0;
            r_ptr    <= '0;
        end else if (w_xfer) begin
            r_valid  <= 1'b1;
            r_data   <= data_in[w_grant];
            r_select <= w_grant;
            r_ptr    <= w_ptr_next;
        end else if (data_out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign select         = r_select;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter
//   Directed scenarios with literal expectations, followed by a random
//   valid/ready phase. A behavioural model of the arbiter is compared
//   against the DUT at every falling edge; the random phase additionally
//   tracks per-stream sequence numbers and grant waiting counts.
module tb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] data_in [N-1:0];
    logic [N-1:0]  data_in_valid;
    logic [N-1:0]  data_in_ready;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic [1:0]    select;

    int vectors = 0;
    int miscompares = 0;

    rr_stream_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .select         (select)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic [1:0]    m_sel   = '0;
    int            m_ptr   = 0;

    function automatic int winner(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] mdl_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = winner(m_ptr, data_in_valid);
        if (rst_n && (!m_valid || data_out_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sel   <= '0;
            m_ptr   <= 0;
        end else if ((!m_valid || data_out_ready) && winner(m_ptr, data_in_valid) >= 0) begin
            m_valid <= 1'b1;
            m_data  <= data_in[winner(m_ptr, data_in_valid)];
            m_sel   <= 2'(winner(m_ptr, data_in_valid));
            m_ptr   <= (winner(m_ptr, data_in_valid) + 1) % N;
        end else if (data_out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 64'(data_in_ready), 64'(mdl_ready()));
        chk("out_valid", 64'(data_out_valid), 64'(m_valid));
        chk("data_out", 64'(data_out), 64'(m_data));
        chk("select", 64'(select), 64'(m_sel));
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fixed_payload();
        for (int i = 0; i < N; i++) data_in[i] = 32'hA0 + 32'(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] d, input logic [1:0] s);
        chk({name, "_valid"}, 64'(data_out_valid), 64'd1);
        chk({name, "_data"}, 64'(data_out), 64'(d));
        chk({name, "_sel"}, 64'(select), 64'(s));
    endtask

    function automatic logic [31:0] payload(input int i, input int s);
        return (32'(i) << 24) | 32'(s);
    endfunction

    // ---------------- random phase state ----------------
    int seq_in  [N];
    int seq_out [N];
    int wcnt    [N];

    task automatic rnd_cycle(input bit feed);
        logic [N-1:0] xf;
        int g;
        @(negedge clk);
        xf = data_in_valid & data_in_ready;
        if (data_out_valid && data_out_ready) begin
            chk("drain_order", 64'(data_out), 64'(payload(int'(select), seq_out[select])));
            seq_out[select]++;
        end
        g = -1;
        for (int i = 0; i < N; i++) if (xf[i]) g = i;
        if (g >= 0) begin
            for (int i = 0; i < N; i++) begin
                if (i == g) wcnt[i] = 0;
                else if (data_in_valid[i]) begin
                    wcnt[i]++;
                    chk("wait_bound", 64'(wcnt[i] < N), 64'd1);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xf[i]) begin
                seq_in[i]++;
                data_in_valid[i] = feed && ($urandom_range(1, 0) == 1);
            end else if (!data_in_valid[i]) begin
                data_in_valid[i] = feed && ($urandom_range(1, 0) == 1);
            end
            data_in[i] = payload(i, seq_in[i]);
        end
        data_out_ready = feed ? ($urandom_range(3, 0) != 0) : 1'b1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int sum_in;
        int sum_out;
        bit done;
        set_fixed_payload();
        data_in_valid  = 4'hF;
        data_out_ready = 1'b1;
        #1 rst_n = 1'b0;

        // Reset with all streams valid; data_out_ready has no effect.
        @(negedge clk);
        chk("rst_in_ready", 64'(data_in_ready), 64'h0);
        chk("rst_out_valid", 64'(data_out_valid), 64'd0);
        chk("rst_select", 64'(select), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        data_out_ready = 1'b0;
        #1;
        chk("rst_in_ready_nr", 64'(data_in_ready), 64'h0);
        chk("rst_out_valid_nr", 64'(data_out_valid), 64'd0);
        data_out_ready = 1'b1;

        // Round robin over all four streams.
        tick();
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 64'(data_in_ready), 64'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_out("rr", 32'hA0 + 32'(k % 4), 2'(k % 4));
        end

        // Skip idle streams, wrap from 3 back to 0.
        data_in_valid = 4'b1010;
        do_reset();
        tick(); expect_out("skip1", 32'hA1, 2'd1);
        tick(); expect_out("skip2", 32'hA3, 2'd3);
        tick(); expect_out("skip3", 32'hA1, 2'd1);
        tick(); expect_out("skip4", 32'hA3, 2'd3);
        data_in_valid = 4'hF;
        tick(); expect_out("wrap0", 32'hA0, 2'd0);

        // Backpressure on a beat from stream 2.
        data_in_valid  = 4'b0100;
        data_out_ready = 1'b0;
        do_reset();
        tick(); expect_out("bp_load", 32'hA2, 2'd2);
        data_in_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", 64'(data_in_ready), 64'h0);
            tick(); expect_out("bp_hold", 32'hA2, 2'd2);
        end
        data_out_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(data_in_ready), 64'b1000);
        tick(); expect_out("bp_next", 32'hA3, 2'd3);
        tick(); expect_out("bp_next2", 32'hA0, 2'd0);

        // Asynchronous reset between edges while holding a beat.
        tick(); expect_out("async_pre", 32'hA1, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(data_out_valid), 64'd0);
        chk("async_data", 64'(data_out), 64'd0);
        chk("async_sel", 64'(select), 64'd0);
        chk("async_ready", 64'(data_in_ready), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick(); expect_out("async_post", 32'hA0, 2'd0);

        // Random valid/ready traffic with sequence-numbered payloads.
        data_in_valid = '0;
        for (int i = 0; i < N; i++) begin
            seq_in[i] = 0; seq_out[i] = 0; wcnt[i] = 0;
            data_in[i] = payload(i, 0);
        end
        do_reset();
        for (int c = 0; c < 10000; c++) rnd_cycle(1'b1);
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            rnd_cycle(1'b0);
            if (data_in_valid == '0 && !data_out_valid) done = 1'b1;
        end
        chk("drain_done", 64'(done), 64'd1);
        sum_in = 0;
        sum_out = 0;
        for (int i = 0; i < N; i++) begin
            sum_in += seq_in[i];
            sum_out += seq_out[i];
        end
        chk("beat_count", 64'(sum_out), 64'(sum_in));
        chk("beats_moved", 64'(sum_in > 1000), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of input streams; legal range 2..64.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width per stream.
REQ-003 SHALL have localparam SELECT_WIDTH = $clog2(NUM_INPUTS), the width of the index outputs.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 data_in  input  DATA_WIDTH x NUM_INPUTS (unpacked [NUM_INPUTS-1:0])  per-stream payload.
REQ-008 data_in_valid  input  NUM_INPUTS  per-stream valid.
REQ-009 data_in_ready  output  NUM_INPUTS  per-stream ready; at most one bit set.
REQ-010 data_out  output  DATA_WIDTH  registered payload of the accepted beat.
REQ-011 data_out_valid  output  1  output register holds a beat.
REQ-012 data_out_ready  input  1  downstream accepts.
REQ-013 select  output  SELECT_WIDTH  registered index of the stream that produced data_out; it feeds downstream select logic.

Function
REQ-014 Handshake: a beat transfers on any port when valid && ready at a rising edge; valid, once high, stays high with stable data until transfer.
REQ-015 load = !data_out_valid || data_out_ready; output register accepts a new beat only when load=1.
REQ-016 Grant: combinational round-robin search of data_in_valid starting at index ptr, ascending, wrapping NUM_INPUTS-1 -> 0; first valid index wins.
REQ-017 data_in_ready[g] = load && any_valid for the winning index g; all other bits 0.
REQ-018 On an input transfer from stream g: data_out <= data_in[g], select <= g, data_out_valid <= 1, ptr <= (g+1) mod NUM_INPUTS.
REQ-019 On a cycle with data_out_valid && data_out_ready and no input transfer: data_out_valid <= 0; data_out and select hold.
REQ-020 Simultaneous output drain and input accept SHALL sustain 1 beat/cycle with no bubble.
REQ-021 With no input transfer, ptr, data_out and select SHALL hold.
REQ-022 Latency: input beat appears on data_out exactly 1 cycle after its transfer edge.
REQ-023 Fairness: with all streams continuously valid and data_out_ready=1, grants SHALL cycle 0,1,...,N-1,0,...
REQ-024 A stream not valid is skipped; ptr advances past the granted index, not past the search start.
REQ-025 ptr wrap: grant to NUM_INPUTS-1 sets ptr to 0.
REQ-026 Backpressure: while data_out_valid && !data_out_ready, data_in_ready SHALL be all-zero and ptr SHALL hold.
REQ-027 No combinational path from data_in to data_out; the only combinational input->output path is data_in_valid/data_out_ready -> data_in_ready.

Reset
REQ-028 On rst_n=0, immediately and regardless of clk: data_out_valid=0, data_out=0, select=0, ptr=0.
REQ-029 During reset data_in_ready SHALL be 0 on all bits.
REQ-030 Reset asserted mid-stream SHALL discard the held beat; the first grant after release SHALL search from index 0.
REQ-031 Deassertion of rst_n SHALL take effect on the following rising clk edge; no transfer occurs on that edge's preceding low phase.

Verification
REQ-032 Reset: hold rst_n=0 with all inputs valid -> data_out_valid=0, data_out_ready ignored, data_in_ready=4'b0000, select=0.
REQ-033 Round robin: N=4, all valid, data_in[i]=32'hA0+i, data_out_ready=1 -> data_out sequence A0,A1,A2,A3,A0 on consecutive cycles, select 0,1,2,3,0.
REQ-034 Skip and wrap: only streams 1 and 3 valid -> grants 1,3,1,3; ptr after grant 3 equals 0.
REQ-035 Backpressure: beat from stream 2 held, data_out_ready=0 for 3 cycles -> data_out stable, data_in_ready=0 throughout; on release same beat drains, next grant from stream 3 onward.
REQ-036 Async reset mid-operation: assert rst_n=0 between edges while data_out_valid=1 -> data_out_valid drops without clock; after release with all valid, first grant is stream 0.
REQ-037 Random: random valid/ready over 10k cycles -> no loss, no duplication, per-stream order preserved, no stream waits more than NUM_INPUTS grants once valid.
